fwd_scoreboard_unit: RTL

- Parametrised successor to the EX-stage forwarding unit.
- Resolves NUM_SRC operands against NUM_STAGES in-flight producer stages with correct per-source youngest-first priority.
- Tracks multi-cycle producers (load, MUL) in a per-register countdown scoreboard and raises a stall to the hazard logic until their result reaches a forwardable stage.
- Sits between ID/EX pipeline registers and the EX operand muxes.

---
 rtl/fwd_pkg.sv | 13 +
 rtl/fwd_src_select.sv | 50 +++++
 rtl/fwd_scoreboard_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared constants, types and helpers for the forwarding scoreboard
package fwd_pkg;

   localparam int SEL_RF = 0;
   localparam int SB_LAT_W = 3;

   typedef logic [SB_LAT_W-1:0] sb_cnt_t;

   function automatic int sel_width(input int num_stages);
      return $clog2(num_stages + 1);
   endfunction

endpackage

// File: rtl/fwd_src_select.sv
// rtl/fwd_src_select.sv - per-source youngest-first forwarding matcher
module fwd_src_select
   import fwd_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int REG_AW     = 4,
   parameter int SEL_W      = 2
) (
   input  logic                         i_id_valid,
   input  logic                         i_used,
   input  logic [REG_AW-1:0]            i_src,
   input  logic [NUM_STAGES*REG_AW-1:0] i_stage_dest,
   input  logic [NUM_STAGES-1:0]        i_stage_wb_en,
   input  logic [NUM_STAGES-1:0]        i_stage_ready,
   output logic [SEL_W-1:0]             o_sel,
   output logic                         o_hazard
);

   logic             w_hit;
   logic             w_hit_ready;
   logic [SEL_W-1:0] w_hit_sel;

   // Scan oldest to youngest so the youngest match is the one left standing;
   // an unready youngest match must block, never expose an older stage.
   always_comb begin
      w_hit       = 1'b0;
      w_hit_ready = 1'b0;
      w_hit_sel   = SEL_W'(SEL_RF);
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
         if (i_stage_wb_en[s] && (i_stage_dest[s*REG_AW +: REG_AW] == i_src)) begin
            w_hit       = 1'b1;
            w_hit_ready = i_stage_ready[s];
            w_hit_sel   = SEL_W'(s + 1);
         end
      end
   end

   always_comb begin
      o_sel    = SEL_W'(SEL_RF);
      o_hazard = 1'b0;
      if (i_id_valid && i_used && w_hit) begin
         if (w_hit_ready) begin
            o_sel = w_hit_sel;
         end else begin
            o_hazard = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// rtl/fwd_scoreboard_unit.sv - EX operand forwarding with multi-cycle producer scoreboard; FWD_PERF_CNT_EN adds stall_cycles
module fwd_scoreboard_unit
   import fwd_pkg::*;
#(
   parameter int NUM_SRC    = 3,
   parameter int NUM_STAGES = 2,
   parameter int REG_AW     = 4,
   parameter int LAT_W      = 3,
   localparam int SEL_W     = sel_width(NUM_STAGES)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]    src,
   input  logic [NUM_SRC-1:0]           src_used,
   input  logic [NUM_STAGES*REG_AW-1:0] stage_dest,
   input  logic [NUM_STAGES-1:0]        stage_wb_en,
   input  logic [NUM_STAGES-1:0]        stage_ready,
   input  logic                         issue_valid,
   input  logic [REG_AW-1:0]            issue_dest,
   input  logic                         issue_wb_en,
   input  logic [LAT_W-1:0]             issue_lat,
   output logic [NUM_SRC*SEL_W-1:0]     sel_src,
   output logic                         stall
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]                  stall_cycles
`endif
);

   localparam int NUM_REGS = 2 ** REG_AW;

   logic [LAT_W-1:0]         r_cnt [NUM_REGS];
   logic [NUM_SRC*SEL_W-1:0] w_sel;
   logic [NUM_SRC-1:0]       w_hazard;
   logic [NUM_SRC-1:0]       w_busy;
   logic                     w_stall;
   logic                     w_issue_fire;
   logic                     w_issue_load;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_src_select #(
         .NUM_STAGES (NUM_STAGES),
         .REG_AW     (REG_AW),
         .SEL_W      (SEL_W)
      ) u_sel (
         .i_id_valid    (id_valid),
         .i_used        (src_used[g]),
         .i_src         (src[g*REG_AW +: REG_AW]),
         .i_stage_dest  (stage_dest),
         .i_stage_wb_en (stage_wb_en),
         .i_stage_ready (stage_ready),
         .o_sel         (w_sel[g*SEL_W +: SEL_W]),
         .o_hazard      (w_hazard[g])
      );

      // Consumer reads the pre-edge counter, so a same-cycle issue is not visible yet.
      assign w_busy[g] = (r_cnt[src[g*REG_AW +: REG_AW]] != '0);
   end

   assign w_stall      = rst_n && id_valid && (|(src_used & (w_busy | w_hazard)));
   assign stall        = w_stall;
   assign sel_src      = rst_n ? w_sel : '0;
   assign w_issue_fire = issue_valid && !w_stall;
   assign w_issue_load = w_issue_fire && issue_wb_en && (issue_lat != '0);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (w_issue_load && (issue_dest == REG_AW'(r))) begin
               r_cnt[r] <= issue_lat;
            end else if (r_cnt[r] != '0) begin
               r_cnt[r] <= r_cnt[r] - 1'b1;
            end
         end
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] r_stall_cycles;

   // Flush does not clear this; it measures lifetime stall pressure.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
      end else if (w_stall) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule
